// File: rtl/pmu_pkg.sv
// Shared definitions for the multi-domain power management unit:
// per-domain state enumeration, default parameter values and a small helper.
package pmu_pkg;

  // Per-domain power sequencing states.
  typedef enum logic [2:0] {
    ST_ON       = 3'd0,
    ST_ISO      = 3'd1,
    ST_SAVE     = 3'd2,
    ST_OFF_WAIT = 3'd3,
    ST_OFF      = 3'd4,
    ST_UP_WAIT  = 3'd5,
    ST_RESTORE  = 3'd6
  } pmu_state_e;

  // Width of one encoded state on the flattened debug bus.
  localparam int STATE_W = 3;

  // Default configuration.
  localparam int DEF_NUM_DOM = 4;
  localparam int DEF_ISO_DLY = 2;
  localparam int DEF_ACK_TO  = 8;
  localparam int DEF_CNT_W   = 8;

  // Larger of two integers; sizes the shared phase timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pmu_dom_fsm.sv
// One power domain: sequencing FSM (ON -> ISO -> SAVE -> OFF_WAIT -> OFF ->
// UP_WAIT -> RESTORE -> ON), a shared phase timer used for the ISO dwell and
// both switch-acknowledge timeouts, a sticky timeout error flag and a
// saturating count of entries into OFF.
module pmu_dom_fsm
  import pmu_pkg::*;
#(
  parameter int ISO_DLY = DEF_ISO_DLY,
  parameter int ACK_TO  = DEF_ACK_TO,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idle_req,
  input  logic             psw_ack,
  input  logic             err_clr,
  output logic             iso_ctrl,
  output logic             psw_ctrl,
  output logic             ret_save,
  output logic             ret_restore,
  output logic             dom_on,
  output logic             err,
  output logic [CNT_W-1:0] sleep_cnt,
  output pmu_state_e       state_dbg
);

  // The timer counts completed cycles in the current timed state, so it only
  // has to reach the larger of the two dwell limits minus one.
  localparam int TMR_MAX = max2(ISO_DLY, ACK_TO);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] ISO_LAST = TMR_W'(ISO_DLY - 1);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TO - 1);

  pmu_state_e       state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             ack_timeout;
  logic             enter_off;

  // State and phase timer registers; reset parks the domain fully on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ON;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state logic: idle_req is only looked at in ON, ISO and OFF; the
  // wait states advance on the switch acknowledge or on timeout.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    ack_timeout = 1'b0;
    case (state)
      ST_ON: begin
        if (idle_req) begin
          state_nxt = ST_ISO;
          tmr_nxt   = '0;
        end
      end
      ST_ISO: begin
        if (!idle_req) begin
          state_nxt = ST_ON;
          tmr_nxt   = '0;
        end else if (tmr == ISO_LAST) begin
          state_nxt = ST_SAVE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      ST_SAVE: begin
        state_nxt = ST_OFF_WAIT;
        tmr_nxt   = '0;
      end
      ST_OFF_WAIT: begin
        if (!psw_ack) begin
          state_nxt = ST_OFF;
          tmr_nxt   = '0;
        end else if (tmr == ACK_LAST) begin
          state_nxt   = ST_OFF;
          tmr_nxt     = '0;
          ack_timeout = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      ST_OFF: begin
        if (!idle_req) begin
          state_nxt = ST_UP_WAIT;
          tmr_nxt   = '0;
        end
      end
      ST_UP_WAIT: begin
        if (psw_ack) begin
          state_nxt = ST_RESTORE;
          tmr_nxt   = '0;
        end else if (tmr == ACK_LAST) begin
          state_nxt   = ST_RESTORE;
          tmr_nxt     = '0;
          ack_timeout = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      ST_RESTORE: begin
        state_nxt = ST_ON;
        tmr_nxt   = '0;
      end
      default: begin
        state_nxt = ST_ON;
        tmr_nxt   = '0;
      end
    endcase
  end

  // OFF is only ever entered from OFF_WAIT.
  assign enter_off = (state == ST_OFF_WAIT) && (state_nxt == ST_OFF);

  // Moore outputs decoded purely from the registered state.
  always_comb begin
    iso_ctrl    = 1'b1;
    psw_ctrl    = 1'b0;
    ret_save    = 1'b0;
    ret_restore = 1'b0;
    dom_on      = 1'b0;
    case (state)
      ST_ON: begin
        iso_ctrl = 1'b0;
        psw_ctrl = 1'b1;
        dom_on   = 1'b1;
      end
      ST_ISO: begin
        psw_ctrl = 1'b1;
      end
      ST_SAVE: begin
        psw_ctrl = 1'b1;
        ret_save = 1'b1;
      end
      ST_OFF_WAIT, ST_OFF: begin
        psw_ctrl = 1'b0;
      end
      ST_UP_WAIT: begin
        psw_ctrl = 1'b1;
      end
      ST_RESTORE: begin
        psw_ctrl    = 1'b1;
        ret_restore = 1'b1;
      end
      default: begin
        iso_ctrl = 1'b0;
        psw_ctrl = 1'b1;
        dom_on   = 1'b1;
      end
    endcase
  end

  // Sticky timeout flag; a timeout in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (ack_timeout) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Saturating count of entries into OFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sleep_cnt <= '0;
    end else if (enter_off && (sleep_cnt != {CNT_W{1'b1}})) begin
      sleep_cnt <= sleep_cnt + CNT_W'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/pmu_multi_domain.sv
// Multi-domain power management unit: NUM_DOM fully independent copies of the
// per-domain sequencer, with per-domain vectors on the boundary.
//
// Handshake with the power switches: psw_ctrl is a level request (1 = close
// the switch); psw_ack is the level status returned by the switch
// (1 = rail up). A power-down completes when psw_ack is seen low, a power-up
// when it is seen high; either wait gives up after ACK_TO cycles, moves on,
// and raises the domain's sticky err flag. idle_req is a level request that
// is only observed in the ON, ISO and OFF states.
module pmu_multi_domain
  import pmu_pkg::*;
#(
  parameter int NUM_DOM = DEF_NUM_DOM,
  parameter int ISO_DLY = DEF_ISO_DLY,
  parameter int ACK_TO  = DEF_ACK_TO,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DOM-1:0]       idle_req,
  input  logic [NUM_DOM-1:0]       psw_ack,
  input  logic [NUM_DOM-1:0]       err_clr,
  output logic [NUM_DOM-1:0]       iso_ctrl,
  output logic [NUM_DOM-1:0]       psw_ctrl,
  output logic [NUM_DOM-1:0]       ret_save,
  output logic [NUM_DOM-1:0]       ret_restore,
  output logic [NUM_DOM-1:0]       dom_on,
  output logic [NUM_DOM-1:0]       err,
  output logic [NUM_DOM*CNT_W-1:0] sleep_cnt,
  output logic [NUM_DOM*STATE_W-1:0] dbg_state
);

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    pmu_state_e dom_state;

    pmu_dom_fsm #(
      .ISO_DLY (ISO_DLY),
      .ACK_TO  (ACK_TO),
      .CNT_W   (CNT_W)
    ) u_dom (
      .clk         (clk),
      .rst         (rst),
      .idle_req    (idle_req[i]),
      .psw_ack     (psw_ack[i]),
      .err_clr     (err_clr[i]),
      .iso_ctrl    (iso_ctrl[i]),
      .psw_ctrl    (psw_ctrl[i]),
      .ret_save    (ret_save[i]),
      .ret_restore (ret_restore[i]),
      .dom_on      (dom_on[i]),
      .err         (err[i]),
      .sleep_cnt   (sleep_cnt[i*CNT_W +: CNT_W]),
      .state_dbg   (dom_state)
    );

    // Expose each domain's state on the flattened debug bus.
    assign dbg_state[i*STATE_W +: STATE_W] = dom_state;
  end

endmodule

// File: tb/tb_pmu_multi_domain.sv
// Bench for pmu_multi_domain: directed scenarios followed by random traffic,
// every cycle compared against a phase/age behavioural model.
module tb_pmu_multi_domain;

  localparam int ND   = 4;
  localparam int IDLY = 2;
  localparam int ATO  = 8;
  localparam int CW   = 8;

  // Model phases (bench-local numbering).
  localparam int P_ON = 0, P_ISO = 1, P_SAVE = 2, P_OFFW = 3;
  localparam int P_OFF = 4, P_UPW = 5, P_REST = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [ND-1:0]     idle_req, psw_ack, err_clr;
  logic [ND-1:0]     iso_ctrl, psw_ctrl, ret_save, ret_restore, dom_on, err;
  logic [ND*CW-1:0]  sleep_cnt;
  logic [ND*3-1:0]   dbg_state;

  logic [ND-1:0]     stuck_hi, stuck_lo;

  int                m_phase[ND];
  int                m_age[ND];
  logic              m_err[ND];
  int                m_cnt[ND];

  int                errors = 0;
  int                checks = 0;

  pmu_multi_domain #(
    .NUM_DOM (ND), .ISO_DLY (IDLY), .ACK_TO (ATO), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .idle_req (idle_req), .psw_ack (psw_ack),
    .err_clr (err_clr), .iso_ctrl (iso_ctrl), .psw_ctrl (psw_ctrl),
    .ret_save (ret_save), .ret_restore (ret_restore), .dom_on (dom_on),
    .err (err), .sleep_cnt (sleep_cnt), .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // ---------------- reference model ----------------
  // Output table {iso, psw, save, restore, on} for each phase.
  function automatic logic [4:0] phase_out(input int p);
    case (p)
      P_ON:    return 5'b01001;
      P_ISO:   return 5'b11000;
      P_SAVE:  return 5'b11100;
      P_OFFW:  return 5'b10000;
      P_OFF:   return 5'b10000;
      P_UPW:   return 5'b11000;
      P_REST:  return 5'b11010;
      default: return 5'bxxxxx;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_phase[d] = P_ON;
      m_age[d]   = 0;
      m_err[d]   = 1'b0;
      m_cnt[d]   = 0;
    end
  endtask

  // Advance one clock edge using the inputs that were stable at that edge.
  // m_age counts cycles already spent in the current phase.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      bit tmo = 0;
      bit to_off = 0;
      case (m_phase[d])
        P_ON:   if (idle_req[d]) begin m_phase[d] = P_ISO; m_age[d] = 1; end
        P_ISO: begin
          if (!idle_req[d]) m_phase[d] = P_ON;
          else if (m_age[d] >= IDLY) m_phase[d] = P_SAVE;
          else m_age[d]++;
        end
        P_SAVE: begin m_phase[d] = P_OFFW; m_age[d] = 1; end
        P_OFFW: begin
          if (!psw_ack[d]) begin m_phase[d] = P_OFF; to_off = 1; end
          else if (m_age[d] >= ATO) begin m_phase[d] = P_OFF; to_off = 1; tmo = 1; end
          else m_age[d]++;
        end
        P_OFF:  if (!idle_req[d]) begin m_phase[d] = P_UPW; m_age[d] = 1; end
        P_UPW: begin
          if (psw_ack[d]) m_phase[d] = P_REST;
          else if (m_age[d] >= ATO) begin m_phase[d] = P_REST; tmo = 1; end
          else m_age[d]++;
        end
        default: m_phase[d] = P_ON;
      endcase
      if (tmo) m_err[d] = 1'b1;
      else if (err_clr[d]) m_err[d] = 1'b0;
      if (to_off && m_cnt[d] < (1 << CW) - 1) m_cnt[d]++;
    end
  endtask

  task automatic compare_all();
    logic [ND-1:0]    e_iso, e_psw, e_sv, e_rs, e_on, e_er;
    logic [ND*CW-1:0] e_cnt;
    for (int d = 0; d < ND; d++) begin
      logic [4:0] o;
      o = phase_out(m_phase[d]);
      e_iso[d] = o[4];
      e_psw[d] = o[3];
      e_sv[d]  = o[2];
      e_rs[d]  = o[1];
      e_on[d]  = o[0];
      e_er[d]  = m_err[d];
      e_cnt[d*CW +: CW] = CW'(m_cnt[d]);
    end
    chk("iso_ctrl", 64'(iso_ctrl), 64'(e_iso));
    chk("psw_ctrl", 64'(psw_ctrl), 64'(e_psw));
    chk("ret_save", 64'(ret_save), 64'(e_sv));
    chk("ret_restore", 64'(ret_restore), 64'(e_rs));
    chk("dom_on", 64'(dom_on), 64'(e_on));
    chk("err", 64'(err), 64'(e_er));
    chk("sleep_cnt", 64'(sleep_cnt), 64'(e_cnt));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: update model at the edge, compare #1 later, then model the
  // switch (ack follows psw_ctrl one cycle later unless forced) and drop
  // the single-cycle error clear.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    compare_all();
    psw_ack = (psw_ctrl | stuck_hi) & ~stuck_lo;
    err_clr = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_phase(input int d, input int p, input int bound, input string tag);
    int n = 0;
    while (m_phase[d] != p && n < bound) begin
      tick();
      n++;
    end
    if (m_phase[d] != p) bound_fail(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b0;
    idle_req = '0;
    psw_ack  = '1;
    err_clr  = '0;
    stuck_hi = '0;
    stuck_lo = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_psw", 64'(psw_ctrl), 64'hF);
    chk("rst_dom_on", 64'(dom_on), 64'hF);
    chk("rst_iso", 64'(iso_ctrl), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Domain 0 power-down with following switch
    idle_req = 4'b0001;
    wait_phase(0, P_OFF, 40, "wait_off_d0");
    ticks(3);
    chk("d0_sleep_cnt", 64'(sleep_cnt[7:0]), 64'd1);
    chk("d0_psw_off", 64'(psw_ctrl), 64'hE);

    // Domain 0 wake
    idle_req[0] = 1'b0;
    wait_phase(0, P_ON, 40, "wait_on_d0");
    chk("d0_dom_on", 64'(dom_on), 64'hF);
    chk("d0_iso_off", 64'(iso_ctrl), 64'h0);

    // Domain 1 single-cycle request: aborts in ISO
    idle_req[1] = 1'b1;
    tick();
    idle_req[1] = 1'b0;
    ticks(4);
    chk("d1_sleep_cnt", 64'(sleep_cnt[15:8]), 64'd0);
    chk("d1_psw", 64'(psw_ctrl), 64'hF);

    // Domain 2 power-down with stuck ack: timeout, then clear
    stuck_hi[2] = 1'b1;
    idle_req[2] = 1'b1;
    wait_phase(2, P_OFF, 40, "wait_off_d2");
    chk("d2_err_set", 64'(err[2]), 64'd1);
    stuck_hi[2] = 1'b0;
    ticks(2);
    err_clr[2] = 1'b1;
    tick();
    chk("d2_err_clr", 64'(err[2]), 64'd0);
    idle_req[2] = 1'b0;
    wait_phase(2, P_ON, 40, "wait_on_d2");

    // Domain 3 counter saturation
    for (int k = 0; k < 260; k++) begin
      idle_req[3] = 1'b1;
      wait_phase(3, P_OFF, 30, "loop_off_d3");
      idle_req[3] = 1'b0;
      wait_phase(3, P_ON, 30, "loop_on_d3");
    end
    chk("d3_sleep_sat", 64'(sleep_cnt[31:24]), 64'd255);

    // All domains in parallel, asynchronous reset inside OFF_WAIT
    idle_req = 4'hF;
    begin
      int n = 0;
      while (!(m_phase[0] == P_OFFW && m_phase[1] == P_OFFW &&
               m_phase[2] == P_OFFW && m_phase[3] == P_OFFW) && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) bound_fail("wait_all_offw");
    end
    chk("all_iso", 64'(iso_ctrl), 64'hF);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_psw", 64'(psw_ctrl), 64'hF);
    chk("arst_iso", 64'(iso_ctrl), 64'h0);
    chk("arst_cnt", 64'(sleep_cnt), 64'h0);
    idle_req = '0;
    psw_ack  = '1;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = $urandom_range(0, ND - 1);
        idle_req[idx] = ~idle_req[idx];
      end
      if ($urandom_range(0, 40) == 0) begin
        stuck_hi = ND'($urandom_range(0, 15));
        stuck_lo = ND'($urandom_range(0, 15)) & ~stuck_hi;
      end
      if ($urandom_range(0, 6) == 0) err_clr = ND'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
